// File: rtl/abs_diff_sad.sv
// abs_diff_sad: multi-channel |a-b| engine that accumulates a sum of absolute differences per block.
// Define ABS_DIFF_SAD_PEAK_EN to add the per-block peak |a-b| output.
module abs_diff_sad #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned BLOCK_LEN = 16,
  parameter int unsigned SIGNED    = 0,
  localparam int unsigned SSW = WIDTH + $clog2(CHANNELS),
  localparam int unsigned SW  = SSW + $clog2(BLOCK_LEN),
  localparam int unsigned BCW = $clog2(BLOCK_LEN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [CHANNELS*WIDTH-1:0] b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SW-1:0]             sad,
  output logic [BCW-1:0]            beat_cnt
`ifdef ABS_DIFF_SAD_PEAK_EN
  ,
  output logic [WIDTH-1:0]          peak
`endif
);

  localparam logic [BCW-1:0] LAST = BCW'(BLOCK_LEN - 1);

  logic                 stall, accept;
  logic                 v1_q, v1_d, v2_q, v2_d, ov_q, ov_d;
  logic [WIDTH-1:0]     d_q [CHANNELS];
  logic [WIDTH-1:0]     d_d [CHANNELS];
  logic [SSW-1:0]       s_q, s_d, sum_c;
  logic [SW-1:0]        acc_q, acc_d, sad_q, sad_d, total_c;
  logic [BCW-1:0]       cnt_q, cnt_d;
`ifdef ABS_DIFF_SAD_PEAK_EN
  logic [WIDTH-1:0]     mx_q, mx_d, bmax_c, run_q, run_d, peak_q, peak_d, runmax_c;
`endif

  // Difference at WIDTH+1 bits; magnitude always fits in WIDTH bits.
  function automatic logic [WIDTH-1:0] absdiff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] df;
    logic           sx, sy;
    sx = (SIGNED != 0) ? x[WIDTH-1] : 1'b0;
    sy = (SIGNED != 0) ? y[WIDTH-1] : 1'b0;
    df = {sx, x} - {sy, y};
    if (df[WIDTH]) df = -df;
    return df[WIDTH-1:0];
  endfunction

  assign stall    = ov_q && !out_ready;
  assign in_ready = !clear && !stall;
  assign accept   = in_valid && in_ready;
  assign total_c  = acc_q + SW'(s_q);

  // Cross-channel reduction of the stage-1 magnitudes.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < int'(CHANNELS); k++) sum_c = sum_c + SSW'(d_q[k]);
`ifdef ABS_DIFF_SAD_PEAK_EN
    bmax_c = '0;
    for (int k = 0; k < int'(CHANNELS); k++) if (d_q[k] > bmax_c) bmax_c = d_q[k];
`endif
  end

`ifdef ABS_DIFF_SAD_PEAK_EN
  assign runmax_c = (mx_q > run_q) ? mx_q : run_q;
`endif

  // Next state: clear wins, stall freezes everything, otherwise the pipe advances.
  always_comb begin
    v1_d  = v1_q;
    d_d   = d_q;
    v2_d  = v2_q;
    s_d   = s_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    ov_d  = ov_q;
    sad_d = sad_q;
`ifdef ABS_DIFF_SAD_PEAK_EN
    mx_d   = mx_q;
    run_d  = run_q;
    peak_d = peak_q;
`endif
    if (clear) begin
      v1_d  = 1'b0;
      v2_d  = 1'b0;
      acc_d = '0;
      cnt_d = '0;
      ov_d  = 1'b0;
`ifdef ABS_DIFF_SAD_PEAK_EN
      run_d = '0;
`endif
    end else if (!stall) begin
      v1_d = accept;
      for (int k = 0; k < int'(CHANNELS); k++)
        d_d[k] = absdiff(a[k*WIDTH +: WIDTH], b[k*WIDTH +: WIDTH]);
      v2_d = v1_q;
      s_d  = sum_c;
      ov_d = 1'b0;
`ifdef ABS_DIFF_SAD_PEAK_EN
      mx_d = bmax_c;
`endif
      if (v2_q) begin
        if (cnt_q == LAST) begin
          sad_d = total_c;
          ov_d  = 1'b1;
          acc_d = '0;
          cnt_d = '0;
`ifdef ABS_DIFF_SAD_PEAK_EN
          peak_d = runmax_c;
          run_d  = '0;
`endif
        end else begin
          acc_d = total_c;
          cnt_d = cnt_q + BCW'(1);
`ifdef ABS_DIFF_SAD_PEAK_EN
          run_d = runmax_c;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      d_q   <= '{default: '0};
      v2_q  <= 1'b0;
      s_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
      sad_q <= '0;
`ifdef ABS_DIFF_SAD_PEAK_EN
      mx_q   <= '0;
      run_q  <= '0;
      peak_q <= '0;
`endif
    end else begin
      v1_q  <= v1_d;
      d_q   <= d_d;
      v2_q  <= v2_d;
      s_q   <= s_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ov_q  <= ov_d;
      sad_q <= sad_d;
`ifdef ABS_DIFF_SAD_PEAK_EN
      mx_q   <= mx_d;
      run_q  <= run_d;
      peak_q <= peak_d;
`endif
    end
  end

  assign out_valid = ov_q;
  assign sad       = sad_q;
  assign beat_cnt  = cnt_q;
`ifdef ABS_DIFF_SAD_PEAK_EN
  assign peak      = peak_q;
`endif

endmodule

// File: tb/tb_abs_diff_sad.sv
// Self-checking bench for abs_diff_sad: unsigned and signed instances share stimulus,
// checked against a block-level SAD model; peak is checked when ABS_DIFF_SAD_PEAK_EN is defined.
module tb_abs_diff_sad;
  localparam int unsigned W   = 8;
  localparam int unsigned CH  = 4;
  localparam int unsigned BL  = 4;
  localparam int unsigned DW  = CH * W;
  localparam int unsigned SW  = W + $clog2(CH) + $clog2(BL);
  localparam int unsigned BCW = $clog2(BL);

  logic           clk = 1'b0;
  logic           rst_n, clear, in_valid, out_ready;
  logic [DW-1:0]  a, b;
  logic           in_ready_u, in_ready_s, out_valid_u, out_valid_s;
  logic [SW-1:0]  sad_u, sad_s;
  logic [BCW-1:0] cnt_u, cnt_s;
`ifdef ABS_DIFF_SAD_PEAK_EN
  logic [W-1:0]   peak_u, peak_s;
`endif

  always #5 clk = ~clk;

  abs_diff_sad #(.WIDTH(W), .CHANNELS(CH), .BLOCK_LEN(BL), .SIGNED(0)) u_uns (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_u),
    .a(a), .b(b), .out_valid(out_valid_u), .out_ready(out_ready), .sad(sad_u), .beat_cnt(cnt_u)
`ifdef ABS_DIFF_SAD_PEAK_EN
    , .peak(peak_u)
`endif
  );

  abs_diff_sad #(.WIDTH(W), .CHANNELS(CH), .BLOCK_LEN(BL), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready), .sad(sad_s), .beat_cnt(cnt_s)
`ifdef ABS_DIFF_SAD_PEAK_EN
    , .peak(peak_s)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: partial block sums and queues of expected block results.
  int part_u, part_s, pk_u, pk_s, part_n;
  int q_sad_u[$], q_sad_s[$], q_pk_u[$], q_pk_s[$];
  int du, ds;
  logic prev_stall;
  int prev_sad_u, prev_sad_s;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int sval(input logic [W-1:0] v, input bit sg);
    if (sg) return int'($signed(v));
    return int'(v);
  endfunction

  function automatic int mag(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_flush();
    part_u = 0; part_s = 0; pk_u = 0; pk_s = 0; part_n = 0;
    q_sad_u.delete(); q_sad_s.delete(); q_pk_u.delete(); q_pk_s.delete();
  endtask

  // Per-cycle monitor: handshake results, stall stability, ready rule, model update.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_flush();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_u", int'(in_ready_u), int'(!clear && !(out_valid_u && !out_ready)));
      chk("in_ready_s", int'(in_ready_s), int'(!clear && !(out_valid_s && !out_ready)));
      if (prev_stall) begin
        chk("stall_valid", int'(out_valid_u), 1);
        chk("stall_sad_u", int'(sad_u), prev_sad_u);
        chk("stall_sad_s", int'(sad_s), prev_sad_s);
      end
      prev_stall = out_valid_u && !out_ready && !clear;
      prev_sad_u = int'(sad_u);
      prev_sad_s = int'(sad_s);
      if (out_valid_u && out_ready) begin
        if (q_sad_u.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result_u: actual=sad %0d required=no result", sad_u);
        end else begin
          chk("sad_u", int'(sad_u), q_sad_u.pop_front());
`ifdef ABS_DIFF_SAD_PEAK_EN
          chk("peak_u", int'(peak_u), q_pk_u.pop_front());
`endif
        end
      end
      if (out_valid_s && out_ready) begin
        if (q_sad_s.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result_s: actual=sad %0d required=no result", sad_s);
        end else begin
          chk("sad_s", int'(sad_s), q_sad_s.pop_front());
`ifdef ABS_DIFF_SAD_PEAK_EN
          chk("peak_s", int'(peak_s), q_pk_s.pop_front());
`endif
        end
      end
      if (clear) begin
        model_flush();
      end else if (in_valid && in_ready_u) begin
        for (int k = 0; k < int'(CH); k++) begin
          du = mag(sval(a[k*W +: W], 1'b0) - sval(b[k*W +: W], 1'b0));
          ds = mag(sval(a[k*W +: W], 1'b1) - sval(b[k*W +: W], 1'b1));
          part_u += du;
          part_s += ds;
          if (du > pk_u) pk_u = du;
          if (ds > pk_s) pk_s = ds;
        end
        part_n++;
        if (part_n == int'(BL)) begin
          q_sad_u.push_back(part_u); q_sad_s.push_back(part_s);
          q_pk_u.push_back(pk_u);    q_pk_s.push_back(pk_s);
          part_u = 0; part_s = 0; pk_u = 0; pk_s = 0; part_n = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present one beat on all channels and hold until it is accepted.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
    int n;
    n = 0;
    a = {CH{av}}; b = {CH{bv}}; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready_u && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL send_timeout: actual=%0d cycles required=<50", n);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid_u && lat < 20);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready_u), 1);
    chk("rst_out_valid", int'(out_valid_u), 0);
    chk("rst_sad_u", int'(sad_u), 0);
    chk("rst_sad_s", int'(sad_s), 0);
    chk("rst_beat_cnt", int'(cnt_u), 0);
`ifdef ABS_DIFF_SAD_PEAK_EN
    chk("rst_peak", int'(peak_u), 0);
`endif
    step();

    // a=200, b=50: unsigned 150/ch, signed |-56-50|=106/ch
    repeat (4) send(8'd200, 8'd50);
    wait_result(lat);
    chk("lat_basic", lat, 3);
    chk("basic_sad_u", int'(sad_u), 2400);
    chk("basic_sad_s", int'(sad_s), 1696);
    chk("cnt_after_blk", int'(cnt_u), 0);
`ifdef ABS_DIFF_SAD_PEAK_EN
    chk("basic_peak_u", int'(peak_u), 150);
    chk("basic_peak_s", int'(peak_s), 106);
`endif
    step();

    // a < b: unsigned 240/ch, signed |10-(-6)|=16/ch
    repeat (4) send(8'd10, 8'd250);
    wait_result(lat);
    chk("lat_altb", lat, 3);
    chk("altb_sad_u", int'(sad_u), 3840);
    chk("altb_sad_s", int'(sad_s), 256);
`ifdef ABS_DIFF_SAD_PEAK_EN
    chk("altb_peak_u", int'(peak_u), 240);
    chk("altb_peak_s", int'(peak_s), 16);
`endif
    step();

    // Signed extremes: |-128-127|=255/ch fills the full 12-bit range
    repeat (4) send(8'h80, 8'h7F);
    wait_result(lat);
    chk("ext_sad_s", int'(sad_s), 4080);
    chk("ext_sad_u", int'(sad_u), 16);
`ifdef ABS_DIFF_SAD_PEAK_EN
    chk("ext_peak_s", int'(peak_s), 255);
    chk("ext_peak_u", int'(peak_u), 1);
`endif
    step();

    // Backpressure: result held five cycles with in_ready low
    out_ready = 1'b0;
    repeat (4) send(8'd200, 8'd50);
    wait_result(lat);
    chk("lat_bp", lat, 3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", int'(in_ready_u), 0);
      chk("bp_sad", int'(sad_u), 2400);
      @(negedge clk);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("bp_ready_after", int'(in_ready_u), 1);
    chk("bp_valid_after", int'(out_valid_u), 0);
    step();
    repeat (4) send(8'd3, 8'd9);
    wait_result(lat);
    chk("post_bp_sad_u", int'(sad_u), 96);
    chk("post_bp_sad_s", int'(sad_s), 96);
    step();

    // Clear mid-block discards the partial block; beat offered during clear is dropped
    repeat (2) send(8'd5, 8'd0);
    repeat (3) @(negedge clk);
    chk("mid_cnt", int'(cnt_u), 2);
    step();
    clear = 1'b1; in_valid = 1'b1; a = {CH{8'd9}}; b = '0;
    step();
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("clr_cnt", int'(cnt_u), 0);
    chk("clr_sad_hold", int'(sad_u), 96);
    chk("clr_valid", int'(out_valid_u), 0);
    step();
    repeat (4) send(8'd1, 8'd3);
    wait_result(lat);
    chk("lat_clr", lat, 3);
    chk("clr_sad_u", int'(sad_u), 32);
    chk("clr_sad_s", int'(sad_s), 32);
    chk("clr_cnt_done", int'(cnt_u), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("clr_single_result", int'(out_valid_u), 0);
    end
    step();

    // Random traffic with random backpressure and occasional clear
    repeat (800) begin
      a = DW'($urandom);
      b = DW'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 59) == 0);
      step();
    end
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while ((q_sad_u.size() != 0 || q_sad_s.size() != 0) && n < 50) begin
      @(negedge clk); n++;
    end
    chk("drain_u", q_sad_u.size(), 0);
    chk("drain_s", q_sad_s.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/abs_diff_sad.md
Name: abs_diff_sad

Overview:
- Multi-channel absolute-difference engine that accumulates a sum of absolute differences (SAD) over fixed-length blocks.
- Each accepted beat carries CHANNELS sample pairs (a, b). The per-channel |a-b| values are summed across channels, then accumulated over BLOCK_LEN beats.
- One SAD result is emitted per block.
- Sits between a sample source and a metric consumer, with valid/ready on both sides.

Parameters:
- WIDTH, 8: bits per sample.
- CHANNELS, 4: sample pairs per beat (>=1).
- BLOCK_LEN, 16: beats per block (>=2).
- SIGNED, 0: 0 = samples are unsigned; 1 = samples are two's complement.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- clear  in  1  synchronous flush of pipeline, accumulator and beat count
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- a  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- b  in  CHANNELS*WIDTH  same packing as a
- out_valid  out  1  SAD result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- sad  out  SW  block SAD; SW = WIDTH + clog2(CHANNELS) + clog2(BLOCK_LEN)
- beat_cnt  out  clog2(BLOCK_LEN)  beats accumulated in the current block

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline valids 0, accumulator 0, beat_cnt 0, out_valid 0, sad 0.
- in_ready is combinational: in_ready = !clear && !(out_valid && !out_ready).
- Stall = out_valid && !out_ready. While stalled, every pipeline register and the accumulator hold.
- Stage 1 (registered, per channel): d_k = |a_k - b_k|.
  - Difference is computed at WIDTH+1 bits, sign-extended if SIGNED=1, zero-extended if SIGNED=0.
  - Magnitude is always <= 2^WIDTH-1 and is stored as WIDTH bits unsigned.
  - a == b gives 0.
- Stage 2 (registered): s = sum of d_k, width WIDTH + clog2(CHANNELS), no overflow possible.
- Stage 3 (accumulator) on a valid s, when not stalled:
  - If beat_cnt < BLOCK_LEN-1: acc <= acc + s; beat_cnt++.
  - If beat_cnt == BLOCK_LEN-1: sad <= acc + s; out_valid <= 1; acc <= 0; beat_cnt <= 0.
- Latency: out_valid rises 3 cycles after the handshake of the last beat of a block, with no stalls.
- Throughput: 1 beat per cycle.
- Handshake:
  - out_valid drops the cycle after out_ready is seen, unless a new result completes in that same cycle. In that case out_valid stays 1 and sad updates.
  - sad is stable while out_valid && !out_ready.
- clear (priority over everything except rst_n):
  - Flushes stage valids, acc, beat_cnt and out_valid, all to 0. sad holds its old value.
  - A partially accumulated block is discarded. The beat presented in the clear cycle is not accepted.
- Reset mid-block: the partial block is discarded; the first accepted beat after release starts a new block.
- in_valid low mid-block: pipeline bubbles, with no effect on accumulation.

Optional Feature:
- Macro: ABS_DIFF_SAD_PEAK_EN.
- Defined:
  - Adds output port peak [WIDTH-1:0]: the maximum d_k over all channels and all beats of the block.
  - peak updates together with sad and holds under the same rules.
  - Internal running max is reset by rst_n, clear and block completion.
  - Reset value of peak is 0.
- Not defined: the port and its logic are absent; all other behaviour is unchanged.

Test Plan (WIDTH=8, CHANNELS=4, BLOCK_LEN=4 unless stated):
- Reset check: rst_n low, then release -> in_ready=1, out_valid=0, sad=0, beat_cnt=0.
- Unsigned, basic: SIGNED=0; 4 back-to-back beats with all a=200, b=50 -> out_valid 3 cycles after 4th beat, sad=2400 (peak=150 if enabled).
- Unsigned, a < b: all a=10, b=250 -> 240 per channel, sad=3840.
- Signed extremes: SIGNED=1; a=8'h80, b=8'h7F on all channels for 4 beats -> 255 per channel, sad=4080 (full SW=12-bit range, no overflow).
- Backpressure: complete a block, hold out_ready=0 for 5 cycles -> in_ready=0 and sad stable; raise out_ready -> handshake, in_ready=1 next cycle, and the next block is correct.
- Clear mid-block: 2 beats (a=5, b=0), pulse clear, then 4 beats (a=1, b=3) -> only one result, sad=32, beat_cnt=0 after completion.
